// File: rtl/radicador_pkg.sv
// rtl/radicador_pkg.sv - shared FSM state type and step-count helper for radicador_param
package radicador_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_CORR = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Number of CALC cycles needed to resolve all root bits.
  function automatic int calc_steps(input int xw, input int bpc);
    return xw / (2 * bpc);
  endfunction

endpackage

// File: rtl/radicador_stage.sv
// rtl/radicador_stage.sv - one combinational non-restoring square-root step
module radicador_stage #(
  parameter int QW = 32
) (
  input  logic [QW+1:0] rem_i,
  input  logic [QW-1:0] root_i,
  input  logic [1:0]    bits_i,
  output logic [QW+1:0] rem_o,
  output logic [QW-1:0] root_o
);

  logic [QW+1:0] shifted;
  logic [QW+1:0] trial;

  // Remainder is two's complement in QW+2 bits; wrap-around of the shift is exact.
  always_comb begin
    shifted = (rem_i << 2) | {{QW{1'b0}}, bits_i};
    trial   = rem_i[QW+1] ? {root_i, 2'b11} : {root_i, 2'b01};
    rem_o   = rem_i[QW+1] ? (shifted + trial) : (shifted - trial);
    root_o  = (root_i << 1) | {{(QW-1){1'b0}}, ~rem_o[QW+1]};
  end

endmodule

// File: rtl/radicador_param.sv
// rtl/radicador_param.sv - iterative integer square root; RADICADOR_REM_EN adds remainder correction
module radicador_param
  import radicador_pkg::*;
#(
  parameter int XW  = 64,
  parameter int BPC = 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  input  logic [XW-1:0] X,
  output logic          FIN,
  output logic          BUSY,
  output logic [XW/2-1:0] COUNT,
  output logic [XW/2:0]   REM
);

  localparam int QW = XW / 2;
  localparam int RW = QW + 2;
  localparam int N  = calc_steps(XW, BPC);
  localparam int IW = $clog2(N + 1);

  if ((XW % 2) != 0 || XW < 4 || XW > 128 ||
      !(BPC == 1 || BPC == 2 || BPC == 4) || ((XW / 2) % BPC) != 0) begin : g_bad_cfg
    $error("radicador_param: illegal XW/BPC combination");
  end

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [QW-1:0] root_q, root_d;
  logic [IW-1:0] iter_q, iter_d;
  logic [QW-1:0] count_q, count_d;
  logic [RW-1:0] rem_step;
  logic [QW-1:0] root_step;
  logic          last_iter;

  // Stages chained through per-iteration nets; radicand pairs consumed MSB first.
  for (genvar k = 0; k < BPC; k++) begin : g_chain
    logic [RW-1:0] rem_in, rem_out;
    logic [QW-1:0] root_in, root_out;
    if (k == 0) begin : g_first
      assign rem_in  = rem_q;
      assign root_in = root_q;
    end else begin : g_next
      assign rem_in  = g_chain[k-1].rem_out;
      assign root_in = g_chain[k-1].root_out;
    end
    radicador_stage #(.QW(QW)) u_stage (
      .rem_i  (rem_in),
      .root_i (root_in),
      .bits_i (x_q[XW-1-2*k -: 2]),
      .rem_o  (rem_out),
      .root_o (root_out)
    );
  end

  assign rem_step  = g_chain[BPC-1].rem_out;
  assign root_step = g_chain[BPC-1].root_out;
  assign last_iter = (iter_q == IW'(N - 1));

`ifdef RADICADOR_REM_EN
  logic [QW:0]   rem_out_q, rem_out_d;
  logic [RW-1:0] rem_corr;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    rem_d   = rem_q;
    root_d  = root_q;
    iter_d  = iter_q;
    count_d = count_q;
`ifdef RADICADOR_REM_EN
    rem_out_d = rem_out_q;
    rem_corr  = rem_q[RW-1] ? (rem_q + {1'b0, root_q, 1'b1}) : rem_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          x_d     = X;
          rem_d   = '0;
          root_d  = '0;
          iter_d  = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        x_d    = x_q << (2 * BPC);
        rem_d  = rem_step;
        root_d = root_step;
        iter_d = iter_q + 1'b1;
        if (last_iter) begin
`ifdef RADICADOR_REM_EN
          state_d = S_CORR;
`else
          count_d = root_step;
          state_d = S_DONE;
`endif
        end
      end
      S_CORR: begin
`ifdef RADICADOR_REM_EN
        rem_d     = rem_corr;
        count_d   = root_q;
        rem_out_d = rem_corr[QW:0];
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!START) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      iter_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      iter_q  <= iter_d;
      count_q <= count_d;
    end
  end

`ifdef RADICADOR_REM_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) rem_out_q <= '0;
    else        rem_out_q <= rem_out_d;
  end
  assign REM = rem_out_q;
`else
  assign REM = '0;
`endif

  assign FIN   = (state_q == S_DONE);
  assign BUSY  = (state_q == S_CALC) || (state_q == S_CORR);
  assign COUNT = count_q;

endmodule

// File: tb/tb_radicador_param.sv
// tb/tb_radicador_param.sv - directed-vector bench for radicador_param (XW=64, BPC=2)
module tb_radicador_param;

  localparam int XW  = 64;
  localparam int BPC = 2;
  localparam int N   = 16;
`ifdef RADICADOR_REM_EN
  localparam int LAT    = N + 2;
  localparam bit REM_EN = 1'b1;
`else
  localparam int LAT    = N + 1;
  localparam bit REM_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET;
  logic          START;
  logic [XW-1:0] X;
  logic          FIN;
  logic          BUSY;
  logic [31:0]   COUNT;
  logic [32:0]   REM;

  int vectors;
  int miscompares;

  radicador_param #(.XW(XW), .BPC(BPC)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .START (START),
    .X     (X),
    .FIN   (FIN),
    .BUSY  (BUSY),
    .COUNT (COUNT),
    .REM   (REM)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called just after the accepting edge; latency counts the cycle in which FIN is first seen.
  task automatic wait_done(input string tag, input logic [31:0] ec, input logic [32:0] er,
                           input bit hold);
    int lat;
    bit ok;
    lat = 1;
    while (!FIN && lat < 200) begin
      @(posedge CLK); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(LAT));
    check({tag, " count"}, 64'(COUNT), 64'(ec));
    check({tag, " rem"}, 64'(REM), REM_EN ? 64'(er) : 64'd0);
    check({tag, " busy_done"}, 64'(BUSY), 64'd0);
    if (hold) begin
      ok = 1'b1;
      repeat (20) begin
        @(posedge CLK); #1;
        if (!FIN || BUSY || COUNT !== ec) ok = 1'b0;
      end
      check({tag, " hold"}, 64'(ok), 64'd1);
    end else begin
      @(negedge CLK); START = 1'b0;
      @(posedge CLK); #1;
      check({tag, " fin_idle"}, 64'(FIN), 64'd0);
    end
  endtask

  task automatic run_vec(input string tag, input logic [63:0] x, input logic [31:0] ec,
                         input logic [32:0] er, input logic [31:0] prev, input bit hold);
    @(negedge CLK); START = 1'b1; X = x;
    @(posedge CLK); #1;
    X = ~x;
    check({tag, " busy"}, 64'(BUSY), 64'd1);
    check({tag, " count_held"}, 64'(COUNT), 64'(prev));
    wait_done(tag, ec, er, hold);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RESET = 1'b0;
    START = 1'b0;
    X     = '0;
    #1;
    check("rst fin", 64'(FIN), 64'd0);
    check("rst busy", 64'(BUSY), 64'd0);
    check("rst count", 64'(COUNT), 64'd0);
    check("rst rem", 64'(REM), 64'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1 check("no start", 64'(BUSY), 64'd0);

    run_vec("zero",   64'd0,                    32'd0,          33'd0,           32'd0,          1'b0);
    run_vec("ones",   64'hFFFF_FFFF_FFFF_FFFF,  32'hFFFF_FFFF,  33'h1_FFFF_FFFE, 32'd0,          1'b0);
    run_vec("1e6",    64'd1000000,              32'd1000,       33'd0,           32'hFFFF_FFFF,  1'b0);
    run_vec("99",     64'd99,                   32'd9,          33'd18,          32'd1000,       1'b0);
    run_vec("sq_max", 64'hFFFF_FFFE_0000_0001,  32'hFFFF_FFFF,  33'd0,           32'd9,          1'b0);
    run_vec("two",    64'd2,                    32'd1,          33'd1,           32'hFFFF_FFFF,  1'b0);
    run_vec("2p32",   64'h1_0000_0000,          32'h1_0000,     33'd0,           32'd1,          1'b0);
    run_vec("15",     64'd15,                   32'd3,          33'd6,           32'h1_0000,     1'b0);

    // Asynchronous reset in the middle of CALC, START kept high throughout.
    @(negedge CLK); START = 1'b1; X = 64'd1000000;
    @(posedge CLK);
    repeat (10) @(posedge CLK);
    #2 RESET = 1'b0;
    #1;
    check("midrst fin", 64'(FIN), 64'd0);
    check("midrst busy", 64'(BUSY), 64'd0);
    check("midrst count", 64'(COUNT), 64'd0);
    check("midrst rem", 64'(REM), 64'd0);
    @(negedge CLK); RESET = 1'b1;
    @(posedge CLK); #1;
    check("rerun busy", 64'(BUSY), 64'd1);
    wait_done("rerun", 32'd1000, 33'd0, 1'b0);

    // START held through DONE must not retrigger; a low cycle then high starts anew.
    run_vec("hold99", 64'd99, 32'd9, 33'd18, 32'd1000, 1'b1);
    @(negedge CLK); START = 1'b0;
    run_vec("after_hold", 64'd16, 32'd4, 33'd0, 32'd9, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/radicador_param.md
RADICADOR_PARAM -- requirements
Module: radicador_param

Interface
REQ-001 SHALL have parameter XW, default 64: radicand width; even, 4..128.
REQ-002 SHALL have parameter BPC, default 1: root bits resolved per clock; 1, 2 or 4; BPC SHALL divide XW/2.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port START  input  1  level request; sampled only in IDLE and DONE.
REQ-006 SHALL have port X  input  XW  unsigned radicand; sampled on the accepting edge only.
REQ-007 SHALL have port FIN  output  1  result valid; high exactly while in DONE.
REQ-008 SHALL have port BUSY  output  1  high in CALC and CORR.
REQ-009 SHALL have port COUNT  output  XW/2  floor(sqrt(X)).
REQ-010 SHALL have port REM  output  XW/2+1  X - COUNT^2.

Function
REQ-011 SHALL implement states IDLE, CALC, CORR, DONE; FIN and BUSY decoded combinationally from state.
REQ-012 IDLE: START=1 -> capture X, clear partial root, remainder and iteration counter, go to CALC; START=0 -> stay.
REQ-013 CALC SHALL run exactly N = XW/(2*BPC) cycles; each cycle applies BPC chained non-restoring steps (remainder sign selects add/subtract, root shifts in ~sign).
REQ-014 Internal remainder SHALL be XW/2+2 bits signed; two's-complement wrap-around within that width SHALL be exact.
REQ-015 Last CALC cycle SHALL go to CORR when RADICADOR_REM_EN is defined, else to DONE.
REQ-016 CORR SHALL last one cycle: if remainder negative, add (root<<1)|1 back; then go to DONE.
REQ-017 COUNT and REM SHALL load on the edge entering DONE and hold until the next completion; intermediate values never appear on them.
REQ-018 Latency from accepting edge to FIN high SHALL be N+1 cycles (N+2 with RADICADOR_REM_EN).
REQ-019 DONE: stay while START=1; START=0 -> IDLE. A START held high SHALL NOT retrigger; a new computation needs START low for at least one cycle.
REQ-020 START and X changes during CALC/CORR SHALL be ignored.
REQ-021 X=0 SHALL give COUNT=0, REM=0; X=2^XW-1 SHALL give COUNT=2^(XW/2)-1, REM=2^(XW/2+1)-2, no overflow.

Reset
REQ-022 RESET low SHALL, asynchronously and at any state including mid-CALC, force IDLE, FIN=0, BUSY=0, COUNT=0, REM=0 and clear all internal registers.
REQ-023 After RESET deassertion, no computation SHALL start until START is sampled high in IDLE.

Configuration
REQ-024 Macro RADICADOR_REM_EN defined: CORR state present, REM carries the true remainder.
REQ-025 Macro RADICADOR_REM_EN undefined: CORR never entered, REM driven constant 0, COUNT unaffected; port list identical.

Structure
REQ-026 Package radicador_pkg SHALL hold the state enum typedef and a constant function returning N from XW and BPC.
REQ-027 Sub-module radicador_stage SHALL implement one combinational non-restoring step (remainder, root, next two radicand bits in; remainder, root out), instantiated BPC times in a generate chain.
REQ-028 Illegal XW/BPC combinations SHALL be rejected at elaboration.

Verification
REQ-029 XW=64,BPC=1, X=0 -> FIN after 34 cycles (REM_EN), COUNT=0, REM=0.
REQ-030 XW=64, X=0xFFFF_FFFF_FFFF_FFFF -> COUNT=0xFFFF_FFFF, REM=0x1_FFFF_FFFE.
REQ-031 XW=64, X=1000000 -> COUNT=1000, REM=0; X=99 -> COUNT=9, REM=18.
REQ-032 XW=64,BPC=2, X=99 -> FIN exactly 17 cycles after accept (REM_EN undefined), COUNT=9, REM=0.
REQ-033 RESET pulsed at CALC cycle 10 -> next edge IDLE, FIN=0, BUSY=0, COUNT=0; START held -> fresh full-length run with correct result.
REQ-034 START held high through DONE for 20 cycles -> FIN stays 1, no restart; START low 1 cycle then high -> new run, X sampled then.
